// File: rtl/cpu_dbg_pkg.sv
// Shared debug-infrastructure types for the CPU trace capture logic.
package cpu_dbg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_t;

endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// Simple dual-port trace storage: synchronous write, registered read.
// Only the read register is reset; the array keeps its contents.
module trace_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Triggerable circular capture of the CPU result bus with oldest-first
// readout over a request/valid handshake.
module cpu_trace_buffer
  import cpu_dbg_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_value,
  input  logic [DATA_W-1:0] trig_mask,
  input  logic [CNT_W-1:0]  post_count,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic [1:0]        state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LP_FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LP_MAX_POST = CNT_W'(DEPTH - 1);

  trace_state_t      r_state;
  trace_state_t      w_state_nxt;
  logic [AW-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic [CNT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_rd_idx;
  logic              r_rd_valid;
  logic              r_rd_last;

  logic              w_capture;
  logic              w_we;
  logic              w_re;
  logic              w_trig;
  logic              w_rd_is_last;
  logic [CNT_W-1:0]  w_post_clamp;
  logic [AW-1:0]     w_rd_addr;

  assign w_post_clamp = (post_count > LP_MAX_POST) ? LP_MAX_POST : post_count;
  assign w_rd_is_last = (r_rd_idx == r_count - CNT_W'(1));
  // wr_ptr and count are frozen in DONE, so the oldest entry is a fixed base
  assign w_rd_addr    = r_wr_ptr - r_count[AW-1:0] + r_rd_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = ARMED;
    end else begin
      case (r_state)
        IDLE:  w_state_nxt = IDLE;
        ARMED: if (w_trig) w_state_nxt = (w_post_clamp == '0) ? DONE : POST;
        POST:  if (sample_valid && r_remaining == CNT_W'(1)) w_state_nxt = DONE;
        DONE:  if (rd_req && w_rd_is_last) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_capture = 1'b0;
    w_re      = 1'b0;
    if (!arm) begin
      w_capture = (r_state == ARMED) || (r_state == POST);
      w_re      = (r_state == DONE) && rd_req;
    end
    w_we   = w_capture && sample_valid;
    w_trig = w_we && (r_state == ARMED) &&
             ((sample & trig_mask) == (trig_value & trig_mask));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_remaining <= '0;
      r_rd_idx    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      r_rd_valid <= w_re;
      r_rd_last  <= w_re && w_rd_is_last;

      if (arm) begin
        r_wr_ptr   <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_we) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (r_count == LP_FULL) r_overflow <= 1'b1;
        else                    r_count    <= r_count + 1'b1;
      end

      if (w_trig)
        r_remaining <= w_post_clamp;
      else if (w_we && r_state == POST)
        r_remaining <= r_remaining - 1'b1;

      if (r_state != DONE) r_rd_idx <= '0;
      else if (w_re)       r_rd_idx <= r_rd_idx + 1'b1;
    end
  end

  trace_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (sample),
    .i_re    (w_re),
    .i_raddr (w_rd_addr),
    .o_rdata (rd_data)
  );

  assign rd_valid = r_rd_valid;
  assign rd_last  = r_rd_last;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign state    = r_state;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer: directed scenarios plus random traffic,
// checked every cycle against a history-queue reference model.
module tb_cpu_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int S_IDLE = 0, S_ARMED = 1, S_POST = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          arm = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;
  logic [DW-1:0] trig_value = '0;
  logic [DW-1:0] trig_mask = '0;
  logic [CW-1:0] post_count = '0;
  logic          rd_req = 1'b0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic [CW-1:0] count;
  logic          overflow;
  logic [1:0]    state;

  always #5 clk = ~clk;

  cpu_trace_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .sample_valid (sample_valid),
    .sample       (sample),
    .trig_value   (trig_value),
    .trig_mask    (trig_mask),
    .post_count   (post_count),
    .rd_req       (rd_req),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .count        (count),
    .overflow     (overflow),
    .state        (state)
  );

  int n_pass = 0, n_total = 0, n_fail = 0;

  // Model: every sample written since the last arm, oldest first.
  logic [DW-1:0] hist[$];
  int            m_state = S_IDLE;
  int            m_rem = 0;
  int            m_ridx = 0;
  bit            m_rdv = 0, m_rdl = 0;
  logic [DW-1:0] m_rdd = '0;

  function automatic int m_count();
    return (hist.size() > DEPTH) ? DEPTH : hist.size();
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit a, input bit v,
                            input logic [DW-1:0] s, input bit rq);
    int pc, n;
    m_rdv = 0;
    m_rdl = 0;
    if (!r) begin
      hist.delete();
      m_state = S_IDLE;
      m_ridx  = 0;
      m_rdd   = '0;
    end else if (a) begin
      hist.delete();
      m_state = S_ARMED;
    end else if (m_state == S_ARMED || m_state == S_POST) begin
      if (v) begin
        hist.push_back(s);
        if (m_state == S_ARMED) begin
          if (((s ^ trig_value) & trig_mask) == '0) begin
            pc = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
            m_rem   = pc;
            m_state = (pc == 0) ? S_DONE : S_POST;
            m_ridx  = 0;
          end
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_state = S_DONE;
            m_ridx  = 0;
          end
        end
      end
    end else if (m_state == S_DONE && rq) begin
      n     = m_count();
      m_rdd = hist[hist.size() - n + m_ridx];
      m_rdv = 1;
      if (m_ridx == n - 1) begin
        m_rdl   = 1;
        m_state = S_IDLE;
      end
      m_ridx++;
    end
  endtask

  task automatic cyc(input bit a, input bit v, input logic [DW-1:0] s,
                     input bit rq, input bit r = 1'b1);
    rst = r; arm = a; sample_valid = v; sample = s; rd_req = rq;
    @(posedge clk);
    model_step(r, a, v, s, rq);
    #1;
    check("state",    DW'(state),    DW'(m_state));
    check("count",    DW'(count),    DW'(m_count()));
    check("overflow", DW'(overflow), DW'(hist.size() > DEPTH));
    check("rd_valid", DW'(rd_valid), DW'(m_rdv));
    check("rd_last",  DW'(rd_last),  DW'(m_rdl));
    check("rd_data",  rd_data,       m_rdd);
  endtask

  task automatic setup(input logic [DW-1:0] tv, input logic [DW-1:0] tm, input int pc);
    trig_value = tv;
    trig_mask  = tm;
    post_count = CW'(pc);
  endtask

  initial begin
    // reset from power-up, then mid-ARMED reset held two cycles
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    setup(32'hFFFF, 32'hFFFFFFFF, 1);
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h11, 0);
    cyc(0, 1, 32'h22, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(0, 0, '0, 0, 0);
    cyc(0, 1, 32'h33, 1);

    // basic capture: trigger on 0x3, two post samples
    setup(32'h3, 32'hFFFFFFFF, 2);
    cyc(1, 1, 32'h99, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, DW'(i), 0);
    cyc(0, 1, 32'h77, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, '0, 1);

    // wrap and overflow, post_count 0
    setup(32'h1B, 32'hFFFFFFFF, 0);
    cyc(1, 0, '0, 0);
    for (int i = 'h10; i <= 'h1B; i++) cyc(0, 1, DW'(i), 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, '0, 1);

    // masked trigger with clamped post_count
    setup(32'hA0000000, 32'hF0000000, 9);
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h00001234, 0);
    cyc(0, 1, 32'hA5A50001, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, DW'(32'h100 + i), 0);
    for (int i = 0; i < 9; i++) cyc(0, 0, '0, 1);

    // gaps in POST
    setup(32'h5, 32'hFFFFFFFF, 3);
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h5, 0);
    for (int i = 0; i < 6; i++) cyc(0, (i % 2) == 0, DW'(32'h60 + i), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, '0, 1);

    // abort: arm during POST, then reset mid-readout
    setup(32'h2, 32'hFFFFFFFF, 3);
    cyc(1, 0, '0, 0);
    cyc(0, 1, 32'h1, 0);
    cyc(0, 1, 32'h2, 0);
    cyc(0, 1, 32'h3, 0);
    cyc(1, 1, 32'h4, 0);
    for (int i = 1; i <= 5; i++) cyc(0, 1, DW'(i), 0);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1);
    cyc(0, 0, '0, 1, 0);
    cyc(0, 0, '0, 1);

    // randomized rounds
    for (int rnd = 0; rnd < 30; rnd++) begin
      logic [DW-1:0] tm;
      case ($urandom_range(0, 2))
        0:       tm = '0;
        1:       tm = 32'h7;
        default: tm = 32'hFFFFFFFF;
      endcase
      setup(DW'($urandom_range(0, 7)), tm, $urandom_range(0, 12));
      cyc(1, 0, '0, 0);
      for (int c = 0; c < 40; c++) begin
        cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            DW'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
            $urandom_range(0, 59) != 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
